// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC3 instruction/data memory responder.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        I_BUSY = 2'b01,
        D_BUSY = 2'b10,
        RESP   = 2'b11
    } state_t;

    localparam int          DEF_INSTR_LAT = 2;
    localparam int          DEF_DATA_LAT  = 3;
    localparam logic [15:0] BASE_ADDR     = 16'h3000;
    // Controller mem_state value meaning "no data access in progress".
    localparam logic [1:0]  MEM_IDLE      = 2'b11;

endpackage

// File: rtl/lc3_mem_array.sv
// DEPTHx16 storage: asynchronous read, access write port plus a backdoor
// write port that wins when both hit the same address on one edge.
module lc3_mem_array #(
    parameter int DEPTH = 65536
) (
    input  logic        clock,
    input  logic [15:0] rd_addr,
    output logic [15:0] rd_data,
    input  logic        wr_en,
    input  logic [15:0] wr_addr,
    input  logic [15:0] wr_data,
    input  logic        bd_en,
    input  logic [15:0] bd_addr,
    input  logic [15:0] bd_data
);

    localparam int AW = $clog2(DEPTH);

    logic [15:0] mem_q [DEPTH];

    assign rd_data = mem_q[rd_addr[AW-1:0]];

    // The backdoor assignment comes last so it overrides a same-address access write.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr[AW-1:0]] <= wr_data;
        end
        if (bd_en) begin
            mem_q[bd_addr[AW-1:0]] <= bd_data;
        end
    end

endmodule

// File: rtl/lc3_mem_model.sv
// Fixed-latency fetch/data responder over one shared array, with backdoor
// preload and saturating completion counters.
module lc3_mem_model
    import lc3_mem_pkg::*;
#(
    parameter int INSTR_LAT = DEF_INSTR_LAT,
    parameter int DATA_LAT  = DEF_DATA_LAT,
    parameter int DEPTH     = 65536
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] pc,
    input  logic        instrmem_rd,
    output logic [15:0] Instr_dout,
    output logic        complete_instr,
    input  logic        Data_req,
    input  logic [15:0] Data_addr,
    input  logic        Data_rd,
    input  logic [15:0] Data_din,
    output logic [15:0] Data_dout,
    output logic        complete_data,
    input  logic        load_en,
    input  logic [15:0] load_addr,
    input  logic [15:0] load_data,
    output logic [31:0] instr_cnt,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] din_q, din_d;
    logic        is_data_q, is_data_d;
    logic        rd_q, rd_d;
    logic [15:0] instr_dout_q, data_dout_q;
    logic [31:0] instr_cnt_q, rd_cnt_q, wr_cnt_q;
    logic [15:0] arr_rd;
    logic        resp_fetch, resp_rd, resp_wr;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        din_d     = din_q;
        is_data_d = is_data_q;
        rd_d      = rd_q;
        case (state_q)
            IDLE: begin
                if (Data_req) begin
                    state_d   = D_BUSY;
                    addr_d    = Data_addr;
                    din_d     = Data_din;
                    rd_d      = Data_rd;
                    is_data_d = 1'b1;
                    cnt_d     = 4'(DATA_LAT - 1);
                end else if (instrmem_rd) begin
                    state_d   = I_BUSY;
                    addr_d    = pc;
                    is_data_d = 1'b0;
                    cnt_d     = 4'(INSTR_LAT - 1);
                end
            end
            I_BUSY: begin
                if (!instrmem_rd)       state_d = IDLE;
                else if (cnt_q == 4'd0) state_d = RESP;
                else                    cnt_d   = cnt_q - 4'd1;
            end
            D_BUSY: begin
                if (!Data_req)          state_d = IDLE;
                else if (cnt_q == 4'd0) state_d = RESP;
                else                    cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_fetch = (state_q == RESP) && !is_data_q;
    assign resp_rd    = (state_q == RESP) && is_data_q && rd_q;
    assign resp_wr    = (state_q == RESP) && is_data_q && !rd_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= 16'd0;
            din_q        <= 16'd0;
            is_data_q    <= 1'b0;
            rd_q         <= 1'b0;
            instr_dout_q <= 16'd0;
            data_dout_q  <= 16'd0;
            instr_cnt_q  <= 32'd0;
            rd_cnt_q     <= 32'd0;
            wr_cnt_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            is_data_q <= is_data_d;
            rd_q      <= rd_d;
            if (resp_fetch) begin
                instr_dout_q <= arr_rd;
                if (instr_cnt_q != '1) instr_cnt_q <= instr_cnt_q + 32'd1;
            end
            if (resp_rd) begin
                data_dout_q <= arr_rd;
                if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (resp_wr && wr_cnt_q != '1) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
        end
    end

    // Read data is visible during the RESP pulse itself, then held in the register.
    assign Instr_dout     = resp_fetch ? arr_rd : instr_dout_q;
    assign Data_dout      = resp_rd ? arr_rd : data_dout_q;
    assign complete_instr = resp_fetch;
    assign complete_data  = (state_q == RESP) && is_data_q;
    assign instr_cnt      = instr_cnt_q;
    assign rd_cnt         = rd_cnt_q;
    assign wr_cnt         = wr_cnt_q;

    lc3_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clock   (clock),
        .rd_addr (addr_q),
        .rd_data (arr_rd),
        .wr_en   (resp_wr && !reset),
        .wr_addr (addr_q),
        .wr_data (din_q),
        .bd_en   (load_en),
        .bd_addr (load_addr),
        .bd_data (load_data)
    );

endmodule
